// File: rtl/if_pc_stage.sv
// Instruction-fetch PC stage: next-PC select, BIOS/IMEM address generation, fetch source mux, squash after redirects.
// Address is presented in cycle N and the matching instruction is on inst_if in cycle N+1.
module if_pc_stage #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [2:0]  pc_sel,
  input  logic [31:0] jal_target,
  input  logic [31:0] alu_target,
  input  logic [31:0] bios_dout,
  input  logic [31:0] imem_dout,
  output logic [11:0] bios_addr,
  output logic [13:0] imem_addr,
  output logic [31:0] pc_if,
  output logic [31:0] inst_if,
  output logic        inst_valid,
  output logic [31:0] fetch_cnt,
  output logic [31:0] flush_cnt
);

  localparam logic [2:0] SEL_RESET = 3'd0;
  localparam logic [2:0] SEL_JAL   = 3'd1;
  localparam logic [2:0] SEL_ALU   = 3'd3;

  logic [31:0] r_pc;
  logic        r_squash;
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_flush_cnt;

  logic [31:0] w_next_raw;
  logic [31:0] w_next_pc;
  logic        w_redirect;
  logic        w_inst_valid;

  assign w_redirect = (pc_sel == SEL_JAL) || (pc_sel == SEL_ALU);

  // Redirects win over stall; stall wins over sequential PC+4 (wraps naturally).
  always_comb begin
    w_next_raw = r_pc + 32'd4;
    if (rst) begin
      w_next_raw = RESET_PC;
    end else begin
      case (pc_sel)
        SEL_RESET: w_next_raw = RESET_PC;
        SEL_JAL:   w_next_raw = jal_target;
        SEL_ALU:   w_next_raw = alu_target;
        default:   w_next_raw = stall ? r_pc : (r_pc + 32'd4);
      endcase
    end
  end

  assign w_next_pc = {w_next_raw[31:2], 2'b00};
  assign bios_addr = w_next_pc[13:2];
  assign imem_addr = w_next_pc[15:2];

  // Reset is gated combinationally so the outputs are quiet for the whole reset cycle.
  assign w_inst_valid = !rst && !r_squash;

  always_ff @(posedge clk) begin
    r_pc <= w_next_pc;
    if (rst) begin
      r_squash    <= 1'b0;
      r_fetch_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      r_squash <= w_redirect;
      if (w_inst_valid && !stall) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (w_redirect) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign pc_if      = r_pc;
  assign inst_if    = !w_inst_valid ? NOP_INST : ((r_pc[31:28] == 4'h4) ? bios_dout : imem_dout);
  assign inst_valid = w_inst_valid;
  assign fetch_cnt  = r_fetch_cnt;
  assign flush_cnt  = r_flush_cnt;

endmodule

// File: tb/tb_if_pc_stage.sv
// Directed bench for if_pc_stage with behavioural one-cycle BIOS/IMEM models (word = tag | word address).
`timescale 1ns/1ps
module tb_if_pc_stage;
  logic        clk = 1'b0;
  logic        rst, stall;
  logic [2:0]  pc_sel;
  logic [31:0] jal_target, alu_target, bios_dout, imem_dout;
  logic [11:0] bios_addr;
  logic [13:0] imem_addr;
  logic [31:0] pc_if, inst_if, fetch_cnt, flush_cnt;
  logic        inst_valid;
  int          n_checks = 0;
  int          n_pass = 0;

  if_pc_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .pc_sel(pc_sel),
    .jal_target(jal_target), .alu_target(alu_target),
    .bios_dout(bios_dout), .imem_dout(imem_dout),
    .bios_addr(bios_addr), .imem_addr(imem_addr),
    .pc_if(pc_if), .inst_if(inst_if), .inst_valid(inst_valid),
    .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    bios_dout <= 32'hB000_0000 | {20'h0, bios_addr};
    imem_dout <= 32'hA000_0000 | {18'h0, imem_addr};
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; pc_sel = 3'd2; jal_target = '0; alu_target = '0;
    tick(); tick();
    n_checks++; if (pc_if !== 32'h4000_0000) $display("FAIL rst_pc: got %h want %h", pc_if, 32'h4000_0000); else n_pass++;
    n_checks++; if (bios_addr !== 12'h000) $display("FAIL rst_bios_addr: got %h want %h", bios_addr, 12'h000); else n_pass++;
    n_checks++; if (inst_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", inst_valid); else n_pass++;
    n_checks++; if (inst_if !== 32'h0000_0013) $display("FAIL rst_inst: got %h want %h", inst_if, 32'h0000_0013); else n_pass++;
    n_checks++; if (fetch_cnt !== 32'd0) $display("FAIL rst_fetch_cnt: got %0d want 0", fetch_cnt); else n_pass++;
    n_checks++; if (flush_cnt !== 32'd0) $display("FAIL rst_flush_cnt: got %0d want 0", flush_cnt); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (inst_valid !== 1'b1) $display("FAIL first_valid: got %b want 1", inst_valid); else n_pass++;
    n_checks++; if (inst_if !== 32'hB000_0000) $display("FAIL first_inst: got %h want %h", inst_if, 32'hB000_0000); else n_pass++;
  endtask

  task automatic test_sequential();
    tick();
    n_checks++; if (pc_if !== 32'h4000_0004) $display("FAIL seq1_pc: got %h want %h", pc_if, 32'h4000_0004); else n_pass++;
    n_checks++; if (inst_if !== 32'hB000_0001) $display("FAIL seq1_inst: got %h want %h", inst_if, 32'hB000_0001); else n_pass++;
    tick();
    n_checks++; if (pc_if !== 32'h4000_0008) $display("FAIL seq2_pc: got %h want %h", pc_if, 32'h4000_0008); else n_pass++;
    n_checks++; if (inst_if !== 32'hB000_0002) $display("FAIL seq2_inst: got %h want %h", inst_if, 32'hB000_0002); else n_pass++;
    n_checks++; if (fetch_cnt !== 32'd2) $display("FAIL seq2_fetch_cnt: got %0d want 2", fetch_cnt); else n_pass++;
  endtask

  task automatic test_jal_redirect();
    pc_sel = 3'd1; jal_target = 32'h1000_0040;
    #1;
    n_checks++; if (imem_addr !== 14'h0010) $display("FAIL jal_imem_addr: got %h want %h", imem_addr, 14'h0010); else n_pass++;
    tick();
    n_checks++; if (pc_if !== 32'h1000_0040) $display("FAIL jal_pc: got %h want %h", pc_if, 32'h1000_0040); else n_pass++;
    n_checks++; if (inst_if !== 32'h0000_0013) $display("FAIL jal_squash_inst: got %h want %h", inst_if, 32'h0000_0013); else n_pass++;
    n_checks++; if (inst_valid !== 1'b0) $display("FAIL jal_squash_valid: got %b want 0", inst_valid); else n_pass++;
    n_checks++; if (fetch_cnt !== 32'd3) $display("FAIL jal_fetch_cnt: got %0d want 3", fetch_cnt); else n_pass++;
    n_checks++; if (flush_cnt !== 32'd1) $display("FAIL jal_flush_cnt: got %0d want 1", flush_cnt); else n_pass++;
    stall = 1'b1; pc_sel = 3'd2;
    tick();
    n_checks++; if (pc_if !== 32'h1000_0040) $display("FAIL jal_hold_pc: got %h want %h", pc_if, 32'h1000_0040); else n_pass++;
    n_checks++; if (inst_if !== 32'hA000_0010) $display("FAIL jal_target_inst: got %h want %h", inst_if, 32'hA000_0010); else n_pass++;
    n_checks++; if (inst_valid !== 1'b1) $display("FAIL jal_target_valid: got %b want 1", inst_valid); else n_pass++;
    stall = 1'b0;
    tick();
    n_checks++; if (pc_if !== 32'h1000_0044) $display("FAIL jal_next_pc: got %h want %h", pc_if, 32'h1000_0044); else n_pass++;
    n_checks++; if (inst_if !== 32'hA000_0011) $display("FAIL jal_next_inst: got %h want %h", inst_if, 32'hA000_0011); else n_pass++;
    n_checks++; if (fetch_cnt !== 32'd4) $display("FAIL jal_next_fetch_cnt: got %0d want 4", fetch_cnt); else n_pass++;
  endtask

  task automatic test_stall();
    pc_sel = 3'd1; jal_target = 32'h4000_0010;
    tick();
    n_checks++; if (flush_cnt !== 32'd2) $display("FAIL stall_pre_flush_cnt: got %0d want 2", flush_cnt); else n_pass++;
    n_checks++; if (fetch_cnt !== 32'd5) $display("FAIL stall_pre_fetch_cnt: got %0d want 5", fetch_cnt); else n_pass++;
    stall = 1'b1; pc_sel = 3'd2;
    tick();
    n_checks++; if (inst_if !== 32'hB000_0004) $display("FAIL stall_entry_inst: got %h want %h", inst_if, 32'hB000_0004); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (pc_if !== 32'h4000_0010) $display("FAIL stall%0d_pc: got %h want %h", i, pc_if, 32'h4000_0010); else n_pass++;
      n_checks++; if (inst_if !== 32'hB000_0004) $display("FAIL stall%0d_inst: got %h want %h", i, inst_if, 32'hB000_0004); else n_pass++;
      n_checks++; if (fetch_cnt !== 32'd5) $display("FAIL stall%0d_fetch_cnt: got %0d want 5", i, fetch_cnt); else n_pass++;
      n_checks++; if (bios_addr !== 12'h004) $display("FAIL stall%0d_bios_addr: got %h want %h", i, bios_addr, 12'h004); else n_pass++;
    end
    stall = 1'b0;
    tick();
    n_checks++; if (pc_if !== 32'h4000_0014) $display("FAIL stall_release_pc: got %h want %h", pc_if, 32'h4000_0014); else n_pass++;
    n_checks++; if (inst_if !== 32'hB000_0005) $display("FAIL stall_release_inst: got %h want %h", inst_if, 32'hB000_0005); else n_pass++;
    n_checks++; if (fetch_cnt !== 32'd6) $display("FAIL stall_release_fetch_cnt: got %0d want 6", fetch_cnt); else n_pass++;
  endtask

  task automatic test_stall_redirect();
    stall = 1'b1; pc_sel = 3'd3; alu_target = 32'h1000_0102;
    #1;
    n_checks++; if (imem_addr !== 14'h0040) $display("FAIL alu_imem_addr: got %h want %h", imem_addr, 14'h0040); else n_pass++;
    tick();
    n_checks++; if (pc_if !== 32'h1000_0100) $display("FAIL alu_pc: got %h want %h", pc_if, 32'h1000_0100); else n_pass++;
    n_checks++; if (inst_valid !== 1'b0) $display("FAIL alu_squash_valid: got %b want 0", inst_valid); else n_pass++;
    n_checks++; if (flush_cnt !== 32'd3) $display("FAIL alu_flush_cnt: got %0d want 3", flush_cnt); else n_pass++;
    n_checks++; if (fetch_cnt !== 32'd6) $display("FAIL alu_fetch_cnt: got %0d want 6", fetch_cnt); else n_pass++;
  endtask

  task automatic test_back_to_back_wrap();
    stall = 1'b0; pc_sel = 3'd1; jal_target = 32'hFFFF_FFFC;
    tick();
    n_checks++; if (pc_if !== 32'hFFFF_FFFC) $display("FAIL b2b_pc: got %h want %h", pc_if, 32'hFFFF_FFFC); else n_pass++;
    n_checks++; if (inst_valid !== 1'b0) $display("FAIL b2b_squash_valid: got %b want 0", inst_valid); else n_pass++;
    n_checks++; if (flush_cnt !== 32'd4) $display("FAIL b2b_flush_cnt: got %0d want 4", flush_cnt); else n_pass++;
    pc_sel = 3'd2;
    #1;
    n_checks++; if (imem_addr !== 14'h0000) $display("FAIL wrap_imem_addr: got %h want %h", imem_addr, 14'h0000); else n_pass++;
    tick();
    n_checks++; if (pc_if !== 32'h0000_0000) $display("FAIL wrap_pc: got %h want %h", pc_if, 32'h0000_0000); else n_pass++;
    n_checks++; if (inst_if !== 32'hA000_0000) $display("FAIL wrap_inst: got %h want %h", inst_if, 32'hA000_0000); else n_pass++;
    n_checks++; if (fetch_cnt !== 32'd6) $display("FAIL wrap_fetch_cnt: got %0d want 6", fetch_cnt); else n_pass++;
  endtask

  task automatic test_pc_sel_decode();
    pc_sel = 3'd5;
    tick();
    n_checks++; if (pc_if !== 32'h0000_0004) $display("FAIL sel5_pc: got %h want %h", pc_if, 32'h0000_0004); else n_pass++;
    n_checks++; if (inst_if !== 32'hA000_0001) $display("FAIL sel5_inst: got %h want %h", inst_if, 32'hA000_0001); else n_pass++;
    pc_sel = 3'd0;
    tick();
    n_checks++; if (pc_if !== 32'h4000_0000) $display("FAIL sel0_pc: got %h want %h", pc_if, 32'h4000_0000); else n_pass++;
    n_checks++; if (inst_valid !== 1'b1) $display("FAIL sel0_valid: got %b want 1", inst_valid); else n_pass++;
    n_checks++; if (flush_cnt !== 32'd4) $display("FAIL sel0_flush_cnt: got %0d want 4", flush_cnt); else n_pass++;
    n_checks++; if (fetch_cnt !== 32'd8) $display("FAIL sel0_fetch_cnt: got %0d want 8", fetch_cnt); else n_pass++;
  endtask

  task automatic test_reset_during_redirect();
    pc_sel = 3'd3; alu_target = 32'h2000_0000; rst = 1'b1;
    tick();
    n_checks++; if (pc_if !== 32'h4000_0000) $display("FAIL rstredir_pc: got %h want %h", pc_if, 32'h4000_0000); else n_pass++;
    n_checks++; if (fetch_cnt !== 32'd0) $display("FAIL rstredir_fetch_cnt: got %0d want 0", fetch_cnt); else n_pass++;
    n_checks++; if (flush_cnt !== 32'd0) $display("FAIL rstredir_flush_cnt: got %0d want 0", flush_cnt); else n_pass++;
    n_checks++; if (inst_valid !== 1'b0) $display("FAIL rstredir_valid: got %b want 0", inst_valid); else n_pass++;
    rst = 1'b0; pc_sel = 3'd2;
    #1;
    n_checks++; if (inst_if !== 32'hB000_0000) $display("FAIL rstredir_first_inst: got %h want %h", inst_if, 32'hB000_0000); else n_pass++;
    tick();
    n_checks++; if (pc_if !== 32'h4000_0004) $display("FAIL rstredir_next_pc: got %h want %h", pc_if, 32'h4000_0004); else n_pass++;
    n_checks++; if (fetch_cnt !== 32'd1) $display("FAIL rstredir_next_fetch_cnt: got %0d want 1", fetch_cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jal_redirect();
    test_stall();
    test_stall_redirect();
    test_back_to_back_wrap();
    test_pc_sel_decode();
    test_reset_during_redirect();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/if_pc_stage.md
IF_PC_STAGE -- requirements
Module: if_pc_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h4000_0000, address fetched first after reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013, instruction substituted for squashed fetches.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 stall  in  1  hold current fetch PC and instruction.
REQ-006 pc_sel  in  3  next-PC select: 0 reset vector, 1 JAL target, 2 PC+4, 3 ALU target (JALR/taken branch), 4-7 treated as 2.
REQ-007 jal_target  in  32  JAL destination from decode.
REQ-008 alu_target  in  32  JALR/branch destination from execute.
REQ-009 bios_dout  in  32  BIOS memory read data, one-cycle synchronous read.
REQ-010 imem_dout  in  32  IMEM read data, one-cycle synchronous read.
REQ-011 bios_addr  out  12  BIOS word address, next_pc[13:2].
REQ-012 imem_addr  out  14  IMEM word address, next_pc[15:2].
REQ-013 pc_if  out  32  PC of the instruction currently on inst_if.
REQ-014 inst_if  out  32  fetched instruction to decode.
REQ-015 inst_valid  out  1  inst_if is a real, non-squashed instruction.
REQ-016 fetch_cnt  out  32  count of valid instructions delivered.
REQ-017 flush_cnt  out  32  count of redirects that squashed a fetch.

Function
REQ-018 next_pc SHALL be combinational: rst -> RESET_PC; else pc_sel 0 -> RESET_PC; 1 -> jal_target; 3 -> alu_target; else stall -> pc_if; else pc_if+4.
REQ-019 Redirect (pc_sel 1 or 3) SHALL take priority over stall; stall SHALL have priority over sequential PC+4.
REQ-020 next_pc[1:0] SHALL be forced to 2'b00 before driving addresses and the PC register.
REQ-021 pc_if SHALL register next_pc every cycle; PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-022 Source select SHALL use registered pc_if: pc_if[31:28]==4'h4 -> bios_dout, else imem_dout.
REQ-023 A redirect in cycle N SHALL set squash flag for cycle N+1; inst_if SHALL equal NOP_INST and inst_valid 0 while squash set.
REQ-024 Squash SHALL clear after one cycle unless another redirect occurs; back-to-back redirects SHALL squash each following cycle.
REQ-025 During stall without redirect pc_if, addresses, inst_if and inst_valid SHALL be unchanged; memory re-read of same address keeps inst_if stable.
REQ-026 fetch_cnt SHALL increment by 1 on each cycle with inst_valid=1 and stall=0; wraps at 2^32.
REQ-027 flush_cnt SHALL increment by 1 on each redirect cycle; wraps at 2^32.
REQ-028 Redirect and stall in same cycle SHALL increment flush_cnt and not fetch_cnt.
REQ-029 Latency: address presented cycle N, matching inst_if valid cycle N+1.

Reset
REQ-030 While rst=1: pc_if <= RESET_PC, bios_addr = RESET_PC[13:2], inst_valid = 0, squash = 0, fetch_cnt = 0, flush_cnt = 0, inst_if = NOP_INST.
REQ-031 First cycle after rst falls: pc_if=RESET_PC, inst_if=bios_dout for RESET_PC, inst_valid=1.
REQ-032 rst asserted mid-stall or mid-redirect SHALL override both within one edge; no counter increments in reset cycles.

Verification
REQ-033 Reset release, pc_sel=2, BIOS preloaded -> pc_if 4000_0000, 4000_0004, 4000_0008 on consecutive cycles, inst_if matches BIOS words 0,1,2, fetch_cnt=3.
REQ-034 pc_sel=1, jal_target=1000_0040 at pc_if=4000_0008 -> next cycle pc_if=1000_0040, inst_if=0000_0013, inst_valid=0; following cycle IMEM word 0x10 valid; flush_cnt=1.
REQ-035 stall=1 for 3 cycles at pc_if=4000_0010 -> pc_if, inst_if, fetch_cnt frozen; release -> pc_if 4000_0014.
REQ-036 stall=1 with pc_sel=3, alu_target=1000_0102 -> pc_if=1000_0100 (low bits forced), squash next cycle, flush_cnt+1, fetch_cnt unchanged.
REQ-037 pc_if=FFFF_FFFC, pc_sel=2 -> pc_if=0000_0000, IMEM source selected.
REQ-038 rst pulsed during redirect cycle -> pc_if=4000_0000, both counters 0, inst_valid=0.
